// File: rtl/dot_seq_pkg.sv
// Shared types and constants for the dot_seq operand sequencer.
package dot_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // MAC pipeline depth from the operand inputs to a settled ACC.
   localparam int MAC_LAT = 3;

endpackage

// File: rtl/dot_seq_mac.sv
// Three-stage signed multiply-accumulate: operand register, product register, accumulator.
module MAC #(
   parameter int INWIDTH_A = 16,
   parameter int INWIDTH_B = 16,
   parameter int ACC_WIDTH = 42
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        EN,
   input  logic signed [INWIDTH_A-1:0] A,
   input  logic signed [INWIDTH_B-1:0] B,
   input  logic                        CLEAR,
   output logic signed [ACC_WIDTH-1:0] ACC
);

   localparam int PW = INWIDTH_A + INWIDTH_B;

   logic signed [INWIDTH_A-1:0] a_q;
   logic signed [INWIDTH_B-1:0] b_q;
   logic                        clr1_q;
   logic signed [PW-1:0]        prod_q;
   logic                        clr2_q;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [PW-1:0]        prod_s;
   logic signed [ACC_WIDTH-1:0] prod_ext_s;

   assign prod_s     = PW'(a_q) * PW'(b_q);
   assign prod_ext_s = ACC_WIDTH'(prod_q);
   assign ACC        = acc_q;

   // Pipeline registers; CLEAR travels with its operands so it lands on the matching product.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         a_q    <= '0;
         b_q    <= '0;
         clr1_q <= 1'b0;
         prod_q <= '0;
         clr2_q <= 1'b0;
         acc_q  <= '0;
      end else if (EN) begin
         a_q    <= A;
         b_q    <= B;
         clr1_q <= CLEAR;
         prod_q <= prod_s;
         clr2_q <= clr1_q;
         acc_q  <= clr2_q ? prod_ext_s : acc_q + prod_ext_s;
      end else begin
         acc_q  <= acc_q;
      end
   end

endmodule

// File: rtl/dot_seq.sv
// Operand sequencer and result drainer for one dot-product lane: weight file,
// ifmap handshake, MAC drive, pipeline drain and a held valid/ready result.
module dot_seq
   import dot_seq_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 42,
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 16
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       wt_wr,
   input  logic [$clog2(MAX_LEN)-1:0] wt_addr,
   input  logic signed [DATA_W-1:0]   wt_data,
   input  logic                       start,
   input  logic [LEN_W-1:0]           cfg_len,
   input  logic [CNT_W-1:0]           cfg_count,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [DATA_W-1:0]   in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_W-1:0]           out_data,
   output logic                       busy,
   output logic                       done
);

   localparam int AW = $clog2(MAX_LEN);

   state_t                     state_q, state_d;
   logic [AW-1:0]              tap_q, tap_d, last_q, last_d;
   logic [CNT_W-1:0]           rem_q, rem_d;
   logic [1:0]                 drain_q, drain_d;
   logic                       in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic                       busy_q, busy_d, done_q, done_d;
   logic [ACC_W-1:0]           out_data_q, out_data_d;
   logic signed [DATA_W-1:0]   wt_q [MAX_LEN];
   logic                       hs_s, start_ok_s;
   logic signed [DATA_W-1:0]   mac_a_s, mac_b_s;
   logic                       mac_clr_s;
   logic signed [ACC_W-1:0]    mac_acc_s;

   assign hs_s       = in_valid && in_ready_q;
   assign start_ok_s = start && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN)) && (cfg_count != '0);

   // Weight file: writable only while idle, cleared by reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < MAX_LEN; i++) wt_q[i] <= '0;
      end else if (wt_wr && (state_q == IDLE)) begin
         wt_q[wt_addr] <= wt_data;
      end else begin
         wt_q[wt_addr] <= wt_q[wt_addr];
      end
   end

   // State, counter and output registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         tap_q       <= '0;
         last_q      <= '0;
         rem_q       <= '0;
         drain_q     <= 2'd0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         last_q      <= last_d;
         rem_q       <= rem_d;
         drain_q     <= drain_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_data_q  <= out_data_d;
      end
   end

   // Next-state and counter update.
   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      last_d  = last_q;
      rem_d   = rem_q;
      drain_d = drain_q;
      case (state_q)
         IDLE: begin
            if (start_ok_s) begin
               last_d  = AW'(cfg_len - LEN_W'(1));
               rem_d   = cfg_count;
               tap_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (hs_s && (tap_q == last_q)) begin
               tap_d   = '0;
               drain_d = 2'(MAC_LAT - 1);
               state_d = DRAIN;
            end else if (hs_s) begin
               tap_d   = tap_q + AW'(1);
            end else begin
               tap_d   = tap_q;
            end
         end
         DRAIN: begin
            if (drain_q == 2'd0) begin
               state_d = HOLD;
            end else begin
               drain_d = drain_q - 2'd1;
            end
         end
         HOLD: begin
            if (out_ready) begin
               rem_d   = rem_q - CNT_W'(1);
               tap_d   = '0;
               state_d = (rem_q == CNT_W'(1)) ? IDLE : RUN;
            end else begin
               state_d = HOLD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the upcoming state so every port comes straight off a flop.
   always_comb begin
      in_ready_d  = (state_d == RUN);
      out_valid_d = (state_d == HOLD);
      busy_d      = (state_d != IDLE);
      done_d      = (state_q == HOLD) && out_ready && (rem_q == CNT_W'(1));
      if ((state_q == DRAIN) && (state_d == HOLD)) begin
         out_data_d = mac_acc_s;
      end else begin
         out_data_d = out_data_q;
      end
   end

   // MAC operands: zeros on idle cycles so the accumulator holds its value.
   always_comb begin
      if (hs_s) begin
         mac_a_s   = in_data;
         mac_b_s   = wt_q[tap_q];
         mac_clr_s = (tap_q == '0);
      end else begin
         mac_a_s   = '0;
         mac_b_s   = '0;
         mac_clr_s = 1'b0;
      end
   end

   MAC #(
      .INWIDTH_A (DATA_W),
      .INWIDTH_B (DATA_W),
      .ACC_WIDTH (ACC_W)
   ) U_mac (
      .CLK   (CLK),
      .RESET (RESET),
      .EN    (1'b1),
      .A     (mac_a_s),
      .B     (mac_b_s),
      .CLEAR (mac_clr_s),
      .ACC   (mac_acc_s)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
